// File: rtl/mem_write_monitor.sv
// Watches processor data-memory stores, logs them in a FIFO, and ends the
// run as PASS on a store of EXPECT_DATA or as FAIL after TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   MemWrite             : data-memory write strobe
//   DataAdr, WriteData   : store address and data
//   log_rd               : pop the head entry of the store log
//   log_data             : head entry {DataAdr, WriteData}
//   log_empty, log_full  : log occupancy flags
//   log_ovf              : sticky, a store was dropped on a full log
//   write_count          : stores seen in RUN (saturating)
//   cycle_count          : cycles spent in RUN
//   match_adr            : address of the store that ended the run as PASS
//   done, pass, fail     : run outcome, from the registered state
module mem_write_monitor #(
   parameter logic [31:0] EXPECT_DATA    = 32'd7,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50,
   parameter int          LOG_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        log_rd,
   output logic [63:0] log_data,
   output logic        log_empty,
   output logic        log_full,
   output logic        log_ovf,
   output logic [15:0] write_count,
   output logic [15:0] cycle_count,
   output logic [31:0] match_adr,
   output logic        done,
   output logic        pass,
   output logic        fail
);

   localparam int PtrW = $clog2(LOG_DEPTH);
   localparam logic [PtrW:0] FullCnt = (PtrW+1)'(LOG_DEPTH);

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] PASS = 2'd1;
   localparam logic [1:0] FAIL = 2'd2;

   logic [1:0]      state;
   logic [63:0]     logMem [LOG_DEPTH];
   logic [PtrW-1:0] wrPtr;
   logic [PtrW-1:0] rdPtr;
   logic [PtrW:0]   occ;

   logic isRun;
   logic store;
   logic isMatch;
   logic isTimeout;
   logic isFull;
   logic doPop;
   logic doPush;

   always_comb begin
      isRun     = (state == RUN);
      store     = isRun & MemWrite;
      isMatch   = store && (WriteData == EXPECT_DATA);
      isTimeout = isRun && (cycle_count == TIMEOUT_CYCLES - 16'd1);
      isFull    = (occ == FullCnt);
      // A pop on an empty log is ignored, so push+pop while empty
      // just pushes and the entry becomes the new head.
      doPop     = log_rd && (occ != '0);
      // A full log can still take a store when a pop frees a slot.
      doPush    = store && (!isFull || doPop);
   end

   // Match is checked first so it wins on the timeout edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         match_adr <= '0;
      end else begin
         case (state)
            RUN: begin
               if (isMatch) begin
                  state     <= PASS;
                  match_adr <= DataAdr;
               end else if (isTimeout) begin
                  state <= FAIL;
               end
            end
            PASS:    state <= PASS;
            FAIL:    state <= FAIL;
            default: state <= FAIL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count <= '0;
         write_count <= '0;
      end else if (isRun) begin
         cycle_count <= cycle_count + 16'd1;
         if (store && write_count != 16'hFFFF)
            write_count <= write_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         occ     <= '0;
         log_ovf <= 1'b0;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + PtrW'(1);
         if (doPop)
            rdPtr <= rdPtr + PtrW'(1);
         case ({doPush, doPop})
            2'b10:   occ <= occ + (PtrW+1)'(1);
            2'b01:   occ <= occ - (PtrW+1)'(1);
            default: occ <= occ;
         endcase
         if (store && isFull && !doPop)
            log_ovf <= 1'b1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!reset && doPush)
         logMem[wrPtr] <= {DataAdr, WriteData};
   end

   assign log_data  = logMem[rdPtr];
   assign log_empty = (occ == '0);
   assign log_full  = isFull;

   assign pass = (state == PASS);
   assign fail = (state == FAIL);
   assign done = pass | fail;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor with a store-log scoreboard.
// A second instance with a short timeout covers the timeout boundary.
module tb_mem_write_monitor;

   localparam int          LD  = 8;
   localparam logic [31:0] EXP = 32'd7;
   localparam int          TO  = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic        log_rd = 1'b0;

   logic [63:0] log_data;
   logic        log_empty, log_full, log_ovf;
   logic [15:0] write_count, cycle_count;
   logic [31:0] match_adr;
   logic        done, pass, fail;

   logic [63:0] t10LogData;
   logic        t10Empty, t10Full, t10Ovf;
   logic [15:0] t10Wc, t10Cc;
   logic [31:0] t10MatchAdr;
   logic        t10Done, t10Pass, t10Fail;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] logQ [$];
   logic [15:0] wcExp;
   logic [15:0] cycExp;
   logic        ovfExp;
   bit          running;

   always #5 clk = ~clk;

   mem_write_monitor dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite),
      .DataAdr(DataAdr), .WriteData(WriteData), .log_rd(log_rd),
      .log_data(log_data), .log_empty(log_empty),
      .log_full(log_full), .log_ovf(log_ovf),
      .write_count(write_count), .cycle_count(cycle_count),
      .match_adr(match_adr), .done(done), .pass(pass), .fail(fail)
   );

   mem_write_monitor #(.TIMEOUT_CYCLES(16'd10)) dut10 (
      .clk(clk), .reset(reset), .MemWrite(MemWrite),
      .DataAdr(DataAdr), .WriteData(WriteData), .log_rd(log_rd),
      .log_data(t10LogData), .log_empty(t10Empty),
      .log_full(t10Full), .log_ovf(t10Ovf),
      .write_count(t10Wc), .cycle_count(t10Cc),
      .match_adr(t10MatchAdr), .done(t10Done),
      .pass(t10Pass), .fail(t10Fail)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetFor(input int n, input bit junk);
      reset = 1'b1;
      if (junk) begin
         MemWrite  = 1'b1;
         DataAdr   = 32'hDEAD;
         WriteData = EXP;
      end
      repeat (n) tick();
      reset    = 1'b0;
      MemWrite = 1'b0;
      logQ.delete();
      wcExp   = '0;
      cycExp  = '0;
      ovfExp  = 1'b0;
      running = 1'b1;
   endtask

   // One clock edge with optional store and pop; the model follows.
   task automatic cycle(input bit mw, input logic [31:0] adr,
                        input logic [31:0] data, input bit pop);
      bit popOk;
      bit pushOk;
      bit wasRun;
      popOk  = pop && (logQ.size() > 0);
      wasRun = running;
      if (popOk)
         check("popData", log_data, logQ[0]);
      MemWrite  = mw;
      DataAdr   = adr;
      WriteData = data;
      log_rd    = pop;
      if (popOk)
         void'(logQ.pop_front());
      if (wasRun && mw) begin
         if (wcExp != 16'hFFFF)
            wcExp++;
         pushOk = (logQ.size() < LD);
         if (pushOk)
            logQ.push_back({adr, data});
         else
            ovfExp = 1'b1;
      end
      if (wasRun) begin
         cycExp++;
         if ((mw && data == EXP) || cycExp == 16'(TO))
            running = 1'b0;
      end
      tick();
      MemWrite = 1'b0;
      log_rd   = 1'b0;
   endtask

   task automatic checkLog(input string tag);
      check({tag, ".empty"}, log_empty, logQ.size() == 0);
      check({tag, ".full"},  log_full,  logQ.size() == LD);
      check({tag, ".ovf"},   log_ovf,   ovfExp);
      check({tag, ".wc"},    write_count, wcExp);
      check({tag, ".cc"},    cycle_count, cycExp);
      if (logQ.size() > 0)
         check({tag, ".head"}, log_data, logQ[0]);
   endtask

   task automatic checkOutcome(input string tag, input bit p,
                               input bit f);
      check({tag, ".pass"}, pass, p);
      check({tag, ".fail"}, fail, f);
      check({tag, ".done"}, done, p | f);
   endtask

   initial begin
      // Matching store on the third store
      resetFor(3, 1'b0);
      checkLog("rst");
      checkOutcome("rst", 1'b0, 1'b0);
      check("rst.madr", match_adr, 32'h0);
      cycle(1'b1, 32'h50, 32'd3, 1'b0);
      cycle(1'b1, 32'h54, 32'd5, 1'b0);
      checkOutcome("preMatch", 1'b0, 1'b0);
      cycle(1'b1, 32'h64, 32'd7, 1'b0);
      checkOutcome("match", 1'b1, 1'b0);
      check("match.madr", match_adr, 32'h64);
      checkLog("match");

      // Stores after PASS are neither counted nor logged
      cycle(1'b1, 32'h80, 32'd9, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);
      checkLog("afterPass");
      checkOutcome("afterPass", 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1);
      checkLog("drained");

      // Timeout with no stores; dut10 times out at edge 10
      resetFor(1, 1'b0);
      repeat (49) cycle(1'b0, 32'h0, 32'h0, 1'b0);
      checkOutcome("to49", 1'b0, 1'b0);
      checkLog("to49");
      check("t10.fail", t10Fail, 1'b1);
      check("t10.pass", t10Pass, 1'b0);
      check("t10.cc", t10Cc, 16'd10);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);
      checkOutcome("to50", 1'b0, 1'b1);
      checkLog("to50");
      repeat (3) cycle(1'b1, 32'h44, 32'd7, 1'b0);
      checkOutcome("frozen", 1'b0, 1'b1);
      checkLog("frozen");

      // Match on the timeout edge of dut10: PASS wins
      resetFor(1, 1'b0);
      repeat (9) cycle(1'b0, 32'h0, 32'h0, 1'b0);
      check("t10.pre.fail", t10Fail, 1'b0);
      check("t10.pre.cc", t10Cc, 16'd9);
      cycle(1'b1, 32'h10, 32'd7, 1'b0);
      check("t10.edge.pass", t10Pass, 1'b1);
      check("t10.edge.fail", t10Fail, 1'b0);
      check("t10.edge.madr", t10MatchAdr, 32'h10);
      checkOutcome("t10.dut", 1'b1, 1'b0);
      checkLog("t10.dut");
      cycle(1'b0, 32'h0, 32'h0, 1'b1);

      // Overflow; reset edges with MemWrite high record nothing
      resetFor(2, 1'b1);
      checkLog("junkRst");
      checkOutcome("junkRst", 1'b0, 1'b0);
      for (int i = 0; i < 9; i++)
         cycle(1'b1, 32'h100 + 32'(4 * i), 32'd1, 1'b0);
      checkLog("ovf");
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 32'h0, 32'h0, 1'b1);
      checkLog("ovfDrain");
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
      checkLog("popEmpty");
      cycle(1'b1, 32'h200, 32'hAB, 1'b1);
      check("pushPopEmpty.head", log_data, {32'h200, 32'hAB});
      checkLog("pushPopEmpty");
      cycle(1'b0, 32'h0, 32'h0, 1'b1);

      // Push and pop together on a full log
      resetFor(1, 1'b0);
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 32'h300 + 32'(4 * i), 32'h30 + 32'(i), 1'b0);
      checkLog("fullAgain");
      cycle(1'b1, 32'h340, 32'h55, 1'b1);
      checkLog("pushPopFull");
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 32'h0, 32'h0, 1'b1);
      checkLog("fullDrain");

      // Reset mid-run flushes the log and restarts
      resetFor(1, 1'b0);
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h40 + 32'(4 * i), 32'd2, 1'b0);
      resetFor(1, 1'b0);
      cycle(1'b1, 32'h20, 32'd7, 1'b0);
      checkLog("restart");
      checkOutcome("restart", 1'b1, 1'b0);
      check("restart.madr", match_adr, 32'h20);
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
      checkLog("restartDrain");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
